dmem_responder: RTL

Data-memory responder for the multi-cycle CPU variant. It sits on the far side of the CPU's load/store port and accepts one request at a time over a valid/ready handshake. It inserts a fixed number of wait states, then performs a word-addressed read or byte-enabled write into an internal RAM. It returns the result, with an error flag, over a second valid/ready handshake.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: types and helpers shared by the data-memory responder.
// Holds the FSM state type, the wait-counter width and the address check.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   localparam int CNT_W = 4;

   // Misaligned or beyond the last word.
   // The full word index is compared, so high address bits never wrap.
   function automatic logic is_err(
      input logic [31:0] addr,
      input logic [31:0] depth
   );
      return (addr[1:0] != 2'b00) ||
             ({2'b00, addr[31:2]} >= depth);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word RAM, byte-enabled synchronous write, asynchronous read.
// Ports: clk, we, be[3:0] lane enables, widx word index, wd write data, rd read data.
module dmem_array
   import mem_pkg::*;
#(
   parameter int DEPTH = 64,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] widx,
   input  logic [31:0]   wd,
   output logic [31:0]   rd
);

   logic [31:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               r_mem[widx][8*i +: 8] <= wd[8*i +: 8];
            end
         end
      end
   end

   assign rd = r_mem[widx];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time load/store responder with fixed wait states.
// Ports: clk, reset (async, active-low), req_* request handshake + payload,
//        resp_* response handshake with load data and error flag.
module dmem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW     = $clog2(DEPTH);
   localparam int LAST_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_I);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_be;
   logic [31:0]       r_rdata;
   logic              r_err;

   logic              w_access;
   logic              w_a_we;
   logic [31:0]       w_a_addr;
   logic [31:0]       w_a_wdata;
   logic [3:0]        w_a_be;
   logic              w_a_err;
   logic              w_mem_we;
   logic [AW-1:0]     w_widx;
   logic [31:0]       w_rd;

   // With no wait states the access happens on the accept edge,
   // so it must use the live request rather than the latched copy.
   assign w_a_we    = (r_state == IDLE) ? req_we    : r_we;
   assign w_a_addr  = (r_state == IDLE) ? req_addr  : r_addr;
   assign w_a_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
   assign w_a_be    = (r_state == IDLE) ? req_be    : r_be;

   assign w_a_err  = is_err(w_a_addr, 32'(DEPTH));
   assign w_widx   = w_a_addr[AW+1:2];
   assign w_mem_we = w_access & w_a_we & ~w_a_err;

   dmem_array #(
      .DEPTH(DEPTH)
   ) u_array (
      .clk  (clk),
      .we   (w_mem_we),
      .be   (w_a_be),
      .widx (w_widx),
      .wd   (w_a_wdata),
      .rd   (w_rd)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_access    = 1'b0;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      unique case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  w_access    = 1'b1;
                  w_state_nxt = RESP;
               end else begin
                  w_state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (r_cnt == LAST) begin
               w_access    = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         if (r_state == IDLE && req_valid) begin
            r_cnt   <= '0;
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
         end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_access) begin
            r_rdata <= (w_a_we || w_a_err) ? 32'h0 : w_rd;
            r_err   <= w_a_err;
         end else if (r_state == RESP && resp_ready) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
         end
      end
   end

   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule
